// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_INC_DEFAULT  = 4;
  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam int unsigned WAIT_W          = 8;

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Counts consecutive imem wait cycles and flags the cycle that reaches the limit.
module fetch_timeout_cnt
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned timeout = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic expire_c
);

  logic [WAIT_W-1:0] cnt_q;

  // Wait-cycle counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + WAIT_W'(1);
    end
  end

  // The waiting cycle that would bring the count up to the limit.
  assign expire_c = inc & (cnt_q == WAIT_W'(timeout - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage controller: issues imem requests, selects next PC, steers IF/ID.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned bit_size = 18,
  parameter int unsigned pc_inc   = PC_INC_DEFAULT,
  parameter int unsigned timeout  = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [bit_size-1:0] pc_cur,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [bit_size-1:0] branch_target,
  input  logic                jump,
  input  logic [bit_size-1:0] jump_target,
  output logic                imem_req,
  output logic [bit_size-1:0] imem_addr,
  input  logic                imem_ready,
  output logic                PCWrite,
  output logic [bit_size-1:0] PCin,
  output logic                IFID_write,
  output logic                IFID_flush,
  output logic                imem_err
);

  fetch_state_e        state_q, state_d;
  logic [bit_size-1:0] redir_q, redir_d;
  logic                err_q;
  logic                redirect;
  logic [bit_size-1:0] target;
  logic                wait_inc, wait_clr, expire_c;

  assign redirect = branch_taken | jump;
  assign target   = branch_taken ? branch_target : jump_target;
  assign wait_inc = rst & ((state_q == ST_FETCH) | (state_q == ST_DRAIN)) & ~imem_ready;
  assign wait_clr = imem_ready | (state_d != state_q);
  assign imem_err = err_q & rst;

  fetch_timeout_cnt #(.timeout(timeout)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .inc      (wait_inc),
    .clr      (wait_clr),
    .expire_c (expire_c)
  );

  // State, pending redirect target and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      redir_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      redir_q <= redir_d;
      if (state_d == ST_ERR) err_q <= 1'b1;
    end
  end

  // Next state and combinational PC / IF-ID control; everything low in reset.
  always_comb begin
    state_d    = state_q;
    redir_d    = redir_q;
    imem_req   = 1'b0;
    imem_addr  = '0;
    PCWrite    = 1'b0;
    PCin       = '0;
    IFID_write = 1'b0;
    IFID_flush = 1'b0;
    if (rst) begin
      unique case (state_q)
        ST_BOOT: state_d = ST_FETCH;
        ST_FETCH: begin
          imem_req  = 1'b1;
          imem_addr = pc_cur;
          if (imem_ready) begin
            if (redirect) begin
              PCWrite    = 1'b1;
              PCin       = target;
              IFID_flush = 1'b1;
            end else if (!stall) begin
              PCWrite    = 1'b1;
              PCin       = pc_cur + bit_size'(pc_inc);
              IFID_write = 1'b1;
            end
          end else if (expire_c) begin
            state_d = ST_ERR;
          end else if (redirect) begin
            redir_d = target;
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = pc_cur;
          if (imem_ready) begin
            PCWrite    = 1'b1;
            PCin       = redirect ? target : redir_q;
            IFID_flush = 1'b1;
            state_d    = ST_FETCH;
          end else if (expire_c) begin
            state_d = ST_ERR;
          end else if (redirect) begin
            redir_d = target;
          end
        end
        ST_ERR: IFID_flush = 1'b1;
        default: state_d = ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] pc_cur;
  logic        stall, branch_taken, jump, imem_ready;
  logic [17:0] branch_target, jump_target;
  logic        imem_req, PCWrite, IFID_write, IFID_flush, imem_err;
  logic [17:0] imem_addr, PCin;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .PCWrite(PCWrite), .PCin(PCin), .IFID_write(IFID_write),
    .IFID_flush(IFID_flush), .imem_err(imem_err)
  );

  // One cycle: inputs applied just after posedge, outputs sampled at negedge.
  task automatic drive(input logic r, input logic [17:0] pc, input logic st,
                       input logic br, input logic [17:0] bt,
                       input logic j, input logic [17:0] jt, input logic rdy);
    @(posedge clk);
    #1;
    rst = r; pc_cur = pc; stall = st; branch_taken = br; branch_target = bt;
    jump = j; jump_target = jt; imem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic test_reset;
    drive(1'b0, 18'h00010, 1'b0, 1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
    drive(1'b0, 18'h00010, 1'b0, 1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
    checks++;
    if ({imem_req, PCWrite, IFID_write, IFID_flush, imem_err} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 00000",
        {imem_req, PCWrite, IFID_write, IFID_flush, imem_err});
    end
    checks++;
    if (dut.state_q !== ST_BOOT) begin
      errors++; $display("FAIL reset_state got %0d exp %0d", dut.state_q, ST_BOOT);
    end
    // first cycle after release is BOOT with outputs low
    drive(1'b1, 18'h00010, 1'b0, 1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
    checks++;
    if (dut.state_q !== ST_BOOT || imem_req !== 1'b0 || PCWrite !== 1'b0) begin
      errors++; $display("FAIL boot_cycle state=%0d req=%b pcw=%b exp BOOT,0,0",
        dut.state_q, imem_req, PCWrite);
    end
  endtask

  task automatic test_sequential;
    drive(1'b1, 18'h00010, 1'b0, 1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
    checks++;
    if ({imem_req, PCWrite, IFID_write, IFID_flush} !== 4'b1110 ||
        PCin !== 18'h00014 || imem_addr !== 18'h00010) begin
      errors++; $display("FAIL sequential ctl=%b PCin=%h addr=%h exp 1110 00014 00010",
        {imem_req, PCWrite, IFID_write, IFID_flush}, PCin, imem_addr);
    end
  endtask

  task automatic test_wrap;
    drive(1'b1, 18'h3FFFC, 1'b0, 1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
    checks++;
    if (PCin !== 18'h00000 || PCWrite !== 1'b1) begin
      errors++; $display("FAIL wrap PCin=%h pcw=%b exp 00000 1", PCin, PCWrite);
    end
  endtask

  task automatic test_priority;
    drive(1'b1, 18'h00020, 1'b0, 1'b1, 18'h00300, 1'b1, 18'h00200, 1'b1);
    checks++;
    if (PCin !== 18'h00300 || {PCWrite, IFID_write, IFID_flush} !== 3'b101) begin
      errors++; $display("FAIL priority_branch PCin=%h ctl=%b exp 00300 101",
        PCin, {PCWrite, IFID_write, IFID_flush});
    end
    drive(1'b1, 18'h00300, 1'b0, 1'b0, 18'h0, 1'b1, 18'h00200, 1'b1);
    checks++;
    if (PCin !== 18'h00200 || IFID_flush !== 1'b1) begin
      errors++; $display("FAIL priority_jump PCin=%h flush=%b exp 00200 1", PCin, IFID_flush);
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 18'h00040, 1'b1, 1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
      checks++;
      if ({PCWrite, IFID_write, IFID_flush} !== 3'b000 || imem_addr !== 18'h00040) begin
        errors++; $display("FAIL stall_%0d ctl=%b addr=%h exp 000 00040",
          i, {PCWrite, IFID_write, IFID_flush}, imem_addr);
      end
    end
    drive(1'b1, 18'h00040, 1'b1, 1'b0, 18'h0, 1'b1, 18'h00080, 1'b1);
    checks++;
    if (PCWrite !== 1'b1 || PCin !== 18'h00080) begin
      errors++; $display("FAIL stall_vs_jump pcw=%b PCin=%h exp 1 00080", PCWrite, PCin);
    end
  endtask

  task automatic test_redirect_drain;
    drive(1'b1, 18'h00044, 1'b0, 1'b1, 18'h00100, 1'b0, 18'h0, 1'b0);
    checks++;
    if (PCWrite !== 1'b0 || IFID_flush !== 1'b0) begin
      errors++; $display("FAIL redir_wait pcw=%b flush=%b exp 0 0", PCWrite, IFID_flush);
    end
    // two more wait cycles in DRAIN; stall must be ignored
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 18'h00044, 1'b1, 1'b0, 18'h0, 1'b0, 18'h0, 1'b0);
      checks++;
      if (dut.state_q !== ST_DRAIN || imem_req !== 1'b1 || PCWrite !== 1'b0) begin
        errors++; $display("FAIL drain_wait_%0d state=%0d req=%b pcw=%b exp DRAIN 1 0",
          i, dut.state_q, imem_req, PCWrite);
      end
    end
    drive(1'b1, 18'h00044, 1'b1, 1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
    checks++;
    if (PCin !== 18'h00100 || {PCWrite, IFID_write, IFID_flush} !== 3'b101) begin
      errors++; $display("FAIL drain_done PCin=%h ctl=%b exp 00100 101",
        PCin, {PCWrite, IFID_write, IFID_flush});
    end
    drive(1'b1, 18'h00100, 1'b0, 1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
    checks++;
    if (dut.state_q !== ST_FETCH || IFID_flush !== 1'b0 || PCin !== 18'h00104) begin
      errors++; $display("FAIL after_drain state=%0d flush=%b PCin=%h exp FETCH 0 00104",
        dut.state_q, IFID_flush, PCin);
    end
  endtask

  task automatic test_drain_override;
    drive(1'b1, 18'h00104, 1'b0, 1'b1, 18'h00100, 1'b0, 18'h0, 1'b0);
    drive(1'b1, 18'h00104, 1'b0, 1'b0, 18'h0, 1'b1, 18'h00500, 1'b0);
    drive(1'b1, 18'h00104, 1'b0, 1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
    checks++;
    if (PCin !== 18'h00500 || IFID_flush !== 1'b1) begin
      errors++; $display("FAIL drain_overwrite PCin=%h flush=%b exp 00500 1", PCin, IFID_flush);
    end
    drive(1'b1, 18'h00500, 1'b0, 1'b0, 18'h0, 1'b1, 18'h00700, 1'b0);
    drive(1'b1, 18'h00500, 1'b0, 1'b1, 18'h00600, 1'b0, 18'h0, 1'b1);
    checks++;
    if (PCin !== 18'h00600 || PCWrite !== 1'b1) begin
      errors++; $display("FAIL drain_same_cycle PCin=%h pcw=%b exp 00600 1", PCin, PCWrite);
    end
  endtask

  task automatic test_timeout_reset;
    drive(1'b1, 18'h00600, 1'b0, 1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
    for (int i = 0; i < 14; i++)
      drive(1'b1, 18'h00604, 1'b0, 1'b0, 18'h0, 1'b0, 18'h0, 1'b0);
    checks++;
    if (dut.state_q !== ST_FETCH || imem_err !== 1'b0) begin
      errors++; $display("FAIL timeout_early state=%0d err=%b exp FETCH 0", dut.state_q, imem_err);
    end
    drive(1'b1, 18'h00604, 1'b0, 1'b0, 18'h0, 1'b0, 18'h0, 1'b0);
    drive(1'b1, 18'h00604, 1'b0, 1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
    checks++;
    if (dut.state_q !== ST_ERR || imem_err !== 1'b1 ||
        {imem_req, PCWrite, IFID_write, IFID_flush} !== 4'b0001) begin
      errors++; $display("FAIL timeout_err state=%0d err=%b ctl=%b exp ERR 1 0001",
        dut.state_q, imem_err, {imem_req, PCWrite, IFID_write, IFID_flush});
    end
    drive(1'b0, 18'h00604, 1'b0, 1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
    checks++;
    if ({imem_req, PCWrite, IFID_write, IFID_flush, imem_err} !== 5'b0) begin
      errors++; $display("FAIL in_reset_outputs got %b exp 00000",
        {imem_req, PCWrite, IFID_write, IFID_flush, imem_err});
    end
    drive(1'b1, 18'h00604, 1'b0, 1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
    checks++;
    if (dut.state_q !== ST_BOOT || imem_err !== 1'b0) begin
      errors++; $display("FAIL reset_from_err state=%0d err=%b exp BOOT 0", dut.state_q, imem_err);
    end
    drive(1'b1, 18'h00000, 1'b0, 1'b0, 18'h0, 1'b0, 18'h0, 1'b1);
    checks++;
    if (imem_req !== 1'b1 || PCin !== 18'h00004) begin
      errors++; $display("FAIL refetch_after_reset req=%b PCin=%h exp 1 00004", imem_req, PCin);
    end
  endtask

  initial begin
    rst = 1'b0; pc_cur = '0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; imem_ready = 1'b0;
    test_reset();
    test_sequential();
    test_wrap();
    test_priority();
    test_stall();
    test_redirect_drain();
    test_drain_override();
    test_timeout_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
